vga_circle_ctrl: RTL and testbench
==================================

Name: vga_circle_ctrl

Overview:
- Frame-rate controller for the circle image generator.
- Each frame it computes the next circle centre (cx, cy) for a bouncing animation and steps a 4-entry colour palette every COLOR_FRAMES frames.
- It presents the centre and colour to the pixel datapath as registered values that stay stable for a whole active frame.
- Sits between the VGA timing block (pix_x/pix_y source) and the circle image block.

Parameters:
- H_ACT, 640, active pixels per line.
- V_ACT, 480, active lines per frame.
- RADIUS, 100, circle radius in pixels; fixes the centre limits.
- STEP_X, 2, horizontal pixels moved per frame.
- STEP_Y, 1, vertical pixels moved per frame.
- COLOR_FRAMES, 60, frames per palette step; must be >= 1.

Ports:
- clk  input  1  pixel clock.
- rst_n  input  1  synchronous active-low reset. One clock domain only; reset is sampled on the rising edge of clk.
- pix_x  input  10  current pixel x; 10'h3ff = outside the active area.
- pix_y  input  10  current pixel y; 10'h3ff = outside the active area.
- en  input  1  animation enable.
- cx  output  10  circle centre x.
- cy  output  10  circle centre y.
- radius  output  7  constant RADIUS.
- color  output  16  RGB565 fill colour.
- frame_tick  output  1  one-cycle pulse when cx, cy and color update.

Behaviour:
- Reset (rst_n low at a clk edge):
  - cx=320, cy=240, dir_x=+, dir_y=+.
  - Palette index 0, color=16'hCF59, frame counter 0, frame_tick 0.
  - State IDLE; shadow registers reset to the same values.
  - Reset asserted mid-sequence discards the pending update.
- Frame-end detect: registered flag fe, set for one cycle after a cycle where pix_x==H_ACT-1 and pix_y==V_ACT-1. Any coordinate equal to 10'h3ff never matches.
- FSM states:
  - IDLE: go to WAIT when en=1.
  - WAIT: on fe and en=1, go to MOVE_X; on en=0, go to IDLE.
  - MOVE_X (1 cycle): compute shadow sx and dir_x.
  - MOVE_Y (1 cycle): compute shadow sy and dir_y, plus palette/frame counter.
  - COMMIT (1 cycle): copy shadows to cx/cy/color; frame_tick=1; go to WAIT.
- en is sampled only in IDLE/WAIT. A MOVE_X..COMMIT sequence always completes once started.
- fe arriving outside WAIT is ignored; it cannot occur at valid frame lengths.
- Latency: fe high in cycle N, MOVE_X in N+1, MOVE_Y in N+2, COMMIT in N+3. Outputs and frame_tick become visible in cycle N+3, and cx/cy/color hold until the next COMMIT. All outputs are registered.
- X arithmetic, in 11-bit unsigned to avoid wrap; limits XMIN=RADIUS, XMAX=H_ACT-1-RADIUS:
  - dir + : if cx+STEP_X >= XMAX, then sx=XMAX and dir_x flips to -; else sx=cx+STEP_X.
  - dir - : if cx <= XMIN+STEP_X, then sx=XMIN and dir_x flips to +; else sx=cx-STEP_X.
- Y arithmetic is identical with YMIN=RADIUS, YMAX=V_ACT-1-RADIUS.
- Axes are independent; a simultaneous corner hit flips both directions in the same frame.
- Colour:
  - Frame counter counts 0..COLOR_FRAMES-1 and increments in MOVE_Y.
  - On wrap to 0 the palette index increments mod 4.
  - Palette: 0=16'hCF59 (eye green), 1=16'hF800, 2=16'h07E0, 3=16'h001F.
- en=0 freezes all outputs at their last committed values; counters hold.
- radius is tied to RADIUS[6:0]. RADIUS must be < 128, checked by an elaboration assertion.

Decomposition:
- Shared package vga_pkg holds:
  - H_ACT and V_ACT defaults.
  - The PIX_INVALID=10'h3ff constant.
  - Palette constants and the palette-index typedef (2 bits).
  - The FSM state enum (IDLE, WAIT, MOVE_X, MOVE_Y, COMMIT).
- One natural sub-module, vga_bounce_axis: an instance per axis, taking pos, dir, step, min and max and producing next pos and next dir combinationally. The controller registers its result in the MOVE state for that axis.

Test Plan:
- Reset, then en=0 for 3 frames -> cx=320, cy=240, color=16'hCF59, frame_tick never pulses.
- en=1, one frame end at (639,479) -> frame_tick exactly 3 cycles after fe; cx=322, cy=241; outputs stable until the next frame end.
- cx preset by stepping to 538 with dir + -> next frame cx=539 and dir_x=-, following frame cx=537. Mirror case: cx=101, dir - gives cx=100, dir_x flips to +.
- COLOR_FRAMES=2, 8 frame ends -> color sequence CF59,CF59,F800,F800,07E0,07E0,001F,001F, then wraps to CF59 on frame 9.
- pix_x=10'h3ff and pix_y=10'h3ff held for a frame, and a frame end with en dropped in WAIT -> no update, FSM returns to IDLE.
- rst_n low during MOVE_Y -> next cycle all outputs at reset values, no frame_tick; the first update occurs on the following fe.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, palette and FSM encoding for the VGA circle image path.
package vga_pkg;

   localparam int unsigned H_ACT_DEF = 640;
   localparam int unsigned V_ACT_DEF = 480;
   localparam int unsigned PIX_W     = 10;
   localparam int unsigned COLOR_W   = 16;

   localparam logic [PIX_W-1:0] PIX_INVALID = 10'h3ff;

   typedef logic [1:0] pal_idx_t;

   localparam logic [COLOR_W-1:0] PAL_EYE_GREEN = 16'hCF59;
   localparam logic [COLOR_W-1:0] PAL_RED       = 16'hF800;
   localparam logic [COLOR_W-1:0] PAL_GREEN     = 16'h07E0;
   localparam logic [COLOR_W-1:0] PAL_BLUE      = 16'h001F;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      MOVE_X,
      MOVE_Y,
      COMMIT
   } state_t;

   // RGB565 colour for a palette slot
   function automatic logic [COLOR_W-1:0] pal_color(input pal_idx_t idx);
      case (idx)
         2'd0:    pal_color = PAL_EYE_GREEN;
         2'd1:    pal_color = PAL_RED;
         2'd2:    pal_color = PAL_GREEN;
         default: pal_color = PAL_BLUE;
      endcase
   endfunction

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing motion: next position and direction, clamped to [min, max].
module vga_bounce_axis
   import vga_pkg::*;
(
   input  logic [PIX_W-1:0] pos,
   input  logic             dir,
   input  logic [PIX_W-1:0] step,
   input  logic [PIX_W-1:0] min,
   input  logic [PIX_W-1:0] max,
   output logic [PIX_W-1:0] next_pos_c,
   output logic             next_dir_c
);

   localparam int unsigned AW = PIX_W + 1;

   logic [AW-1:0] pos_w;
   logic [AW-1:0] step_w;
   logic [AW-1:0] sum_w;
   logic [AW-1:0] lim_lo_w;

   // Extra bit keeps pos+step and min+step from wrapping
   assign pos_w    = AW'(pos);
   assign step_w   = AW'(step);
   assign sum_w    = pos_w + step_w;
   assign lim_lo_w = AW'(min) + step_w;

   always_comb begin
      next_pos_c = pos;
      next_dir_c = dir;
      if (dir) begin
         if (sum_w >= AW'(max)) begin
            next_pos_c = max;
            next_dir_c = 1'b0;
         end else begin
            next_pos_c = PIX_W'(sum_w);
         end
      end else begin
         if (pos_w <= lim_lo_w) begin
            next_pos_c = min;
            next_dir_c = 1'b1;
         end else begin
            next_pos_c = PIX_W'(pos_w - step_w);
         end
      end
   end

endmodule

// File: rtl/vga_circle_ctrl.sv
// Per-frame controller for the circle image: bouncing centre and stepped palette colour.
module vga_circle_ctrl
   import vga_pkg::*;
#(
   parameter int unsigned H_ACT        = H_ACT_DEF,
   parameter int unsigned V_ACT        = V_ACT_DEF,
   parameter int unsigned RADIUS       = 100,
   parameter int unsigned STEP_X       = 2,
   parameter int unsigned STEP_Y       = 1,
   parameter int unsigned COLOR_FRAMES = 60
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PIX_W-1:0]   pix_x,
   input  logic [PIX_W-1:0]   pix_y,
   input  logic               en,
   output logic [PIX_W-1:0]   cx,
   output logic [PIX_W-1:0]   cy,
   output logic [6:0]         radius,
   output logic [COLOR_W-1:0] color,
   output logic               frame_tick
);

   localparam int unsigned XMIN   = RADIUS;
   localparam int unsigned XMAX   = H_ACT - 1 - RADIUS;
   localparam int unsigned YMIN   = RADIUS;
   localparam int unsigned YMAX   = V_ACT - 1 - RADIUS;
   localparam int unsigned X_RST  = H_ACT / 2;
   localparam int unsigned Y_RST  = V_ACT / 2;
   localparam int unsigned FCNT_W = (COLOR_FRAMES > 1) ? $clog2(COLOR_FRAMES) : 1;

   if (RADIUS >= 128) begin : g_radius_chk
      $error("vga_circle_ctrl: RADIUS must be below 128");
   end
   if (COLOR_FRAMES < 1) begin : g_frames_chk
      $error("vga_circle_ctrl: COLOR_FRAMES must be at least 1");
   end

   state_t            state, state_nxt;
   logic              fe;
   logic              dir_x, dir_y;
   logic [PIX_W-1:0]  sx;
   pal_idx_t          pal_idx;
   logic [FCNT_W-1:0] fcnt;
   logic [PIX_W-1:0]  nx_c, ny_c;
   logic              ndx_c, ndy_c;

   assign radius = 7'(RADIUS);

   vga_bounce_axis u_axis_x (
      .pos        (cx),
      .dir        (dir_x),
      .step       (PIX_W'(STEP_X)),
      .min        (PIX_W'(XMIN)),
      .max        (PIX_W'(XMAX)),
      .next_pos_c (nx_c),
      .next_dir_c (ndx_c)
   );

   vga_bounce_axis u_axis_y (
      .pos        (cy),
      .dir        (dir_y),
      .step       (PIX_W'(STEP_Y)),
      .min        (PIX_W'(YMIN)),
      .max        (PIX_W'(YMAX)),
      .next_pos_c (ny_c),
      .next_dir_c (ndy_c)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en) state_nxt = WAIT;
         WAIT: begin
            if (!en)     state_nxt = IDLE;
            else if (fe) state_nxt = MOVE_X;
         end
         MOVE_X:  state_nxt = MOVE_Y;
         MOVE_Y:  state_nxt = COMMIT;
         COMMIT:  state_nxt = WAIT;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs load on the MOVE_Y->COMMIT edge so they are visible together with frame_tick
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fe         <= 1'b0;
         cx         <= PIX_W'(X_RST);
         cy         <= PIX_W'(Y_RST);
         sx         <= PIX_W'(X_RST);
         dir_x      <= 1'b1;
         dir_y      <= 1'b1;
         pal_idx    <= 2'd0;
         fcnt       <= '0;
         color      <= PAL_EYE_GREEN;
         frame_tick <= 1'b0;
      end else begin
         fe <= (pix_x != PIX_INVALID) && (pix_y != PIX_INVALID) &&
               (pix_x == PIX_W'(H_ACT - 1)) && (pix_y == PIX_W'(V_ACT - 1));
         frame_tick <= 1'b0;
         case (state)
            MOVE_X: begin
               sx    <= nx_c;
               dir_x <= ndx_c;
            end
            MOVE_Y: begin
               dir_y      <= ndy_c;
               cx         <= sx;
               cy         <= ny_c;
               color      <= pal_color(pal_idx);
               frame_tick <= 1'b1;
               if (fcnt == FCNT_W'(COLOR_FRAMES - 1)) begin
                  fcnt    <= '0;
                  pal_idx <= pal_idx + 2'd1;
               end else begin
                  fcnt <= fcnt + FCNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_circle_ctrl.sv
// Directed bench for vga_circle_ctrl: checkpoint table over many frames plus corner sequences.
module tb_vga_circle_ctrl;
   import vga_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  pix_x, pix_y;
   logic        en;
   logic [9:0]  cx, cy;
   logic [6:0]  radius;
   logic [15:0] color;
   logic        frame_tick;

   int n_checks = 0;
   int n_fail   = 0;

   vga_circle_ctrl #(.COLOR_FRAMES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .en         (en),
      .cx         (cx),
      .cy         (cy),
      .radius     (radius),
      .color      (color),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          frame;
      logic [9:0]  cx;
      logic [9:0]  cy;
      logic [15:0] color;
   } chkpt_t;

   chkpt_t tbl[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one frame-end pixel, then watch 8 cycles for frame_tick
   task automatic do_frame(output int tick_at, output int tick_cnt);
      tick_at  = -1;
      tick_cnt = 0;
      pix_x = 10'd639;
      pix_y = 10'd479;
      cyc(1);
      pix_x = PIX_INVALID;
      pix_y = PIX_INVALID;
      for (int i = 1; i <= 8; i++) begin
         cyc(1);
         if (frame_tick) begin
            tick_cnt++;
            if (tick_at < 0) tick_at = i;
         end
      end
   endtask

   initial begin
      int ta, tc, frame_no, ticks;

      tbl[0]  = '{1,   10'd322, 10'd241, 16'hCF59};
      tbl[1]  = '{2,   10'd324, 10'd242, 16'hCF59};
      tbl[2]  = '{3,   10'd326, 10'd243, 16'hF800};
      tbl[3]  = '{4,   10'd328, 10'd244, 16'hF800};
      tbl[4]  = '{5,   10'd330, 10'd245, 16'h07E0};
      tbl[5]  = '{6,   10'd332, 10'd246, 16'h07E0};
      tbl[6]  = '{7,   10'd334, 10'd247, 16'h001F};
      tbl[7]  = '{8,   10'd336, 10'd248, 16'h001F};
      tbl[8]  = '{9,   10'd338, 10'd249, 16'hCF59};
      tbl[9]  = '{109, 10'd538, 10'd349, 16'h07E0};
      tbl[10] = '{110, 10'd539, 10'd350, 16'h07E0};
      tbl[11] = '{111, 10'd537, 10'd351, 16'h001F};
      tbl[12] = '{329, 10'd101, 10'd189, 16'hCF59};
      tbl[13] = '{330, 10'd100, 10'd188, 16'hCF59};
      tbl[14] = '{331, 10'd102, 10'd187, 16'hF800};

      rst_n = 1'b0;
      en    = 1'b0;
      pix_x = PIX_INVALID;
      pix_y = PIX_INVALID;
      cyc(3);
      rst_n = 1'b1;
      cyc(1);

      chk("reset_cx", 32'(cx), 32'd320);
      chk("reset_cy", 32'(cy), 32'd240);
      chk("reset_color", 32'(color), 32'hCF59);
      chk("reset_tick", 32'(frame_tick), 32'd0);
      chk("radius", 32'(radius), 32'd100);

      // Disabled: three frame ends must not move anything
      ticks = 0;
      for (int f = 0; f < 3; f++) begin
         do_frame(ta, tc);
         ticks += tc;
      end
      chk("dis_ticks", 32'(ticks), 32'd0);
      chk("dis_cx", 32'(cx), 32'd320);
      chk("dis_cy", 32'(cy), 32'd240);
      chk("dis_color", 32'(color), 32'hCF59);

      en = 1'b1;
      cyc(1);
      frame_no = 0;
      foreach (tbl[k]) begin
         while (frame_no < tbl[k].frame) begin
            do_frame(ta, tc);
            frame_no++;
         end
         chk($sformatf("f%0d_tick_at", tbl[k].frame), 32'(ta), 32'd3);
         chk($sformatf("f%0d_tick_cnt", tbl[k].frame), 32'(tc), 32'd1);
         chk($sformatf("f%0d_cx", tbl[k].frame), 32'(cx), 32'(tbl[k].cx));
         chk($sformatf("f%0d_cy", tbl[k].frame), 32'(cy), 32'(tbl[k].cy));
         chk($sformatf("f%0d_color", tbl[k].frame), 32'(color), 32'(tbl[k].color));
      end

      // Non-final pixels and invalid coordinates: outputs hold, no tick
      ticks = 0;
      for (int i = 0; i < 40; i++) begin
         case (i % 4)
            0: begin pix_x = 10'($urandom_range(0, 638)); pix_y = 10'($urandom_range(0, 479)); end
            1: begin pix_x = PIX_INVALID; pix_y = PIX_INVALID; end
            2: begin pix_x = 10'd639;     pix_y = PIX_INVALID; end
            default: begin pix_x = PIX_INVALID; pix_y = 10'd479; end
         endcase
         cyc(1);
         if (frame_tick) ticks++;
      end
      pix_x = PIX_INVALID;
      pix_y = PIX_INVALID;
      cyc(6);
      if (frame_tick) ticks++;
      chk("hold_ticks", 32'(ticks), 32'd0);
      chk("hold_cx", 32'(cx), 32'd102);
      chk("hold_cy", 32'(cy), 32'd187);
      chk("hold_color", 32'(color), 32'hF800);

      // Frame end while en dropped in WAIT: no update, back to IDLE
      en = 1'b0;
      do_frame(ta, tc);
      chk("endrop_ticks", 32'(tc), 32'd0);
      chk("endrop_state", 32'(dut.state), 32'(IDLE));
      chk("endrop_cx", 32'(cx), 32'd102);
      chk("endrop_color", 32'(color), 32'hF800);

      // Reset asserted while in MOVE_Y discards the pending update
      en = 1'b1;
      cyc(1);
      pix_x = 10'd639;
      pix_y = 10'd479;
      cyc(1);
      pix_x = PIX_INVALID;
      pix_y = PIX_INVALID;
      cyc(2);
      chk("rst_mid_state", 32'(dut.state), 32'(MOVE_Y));
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      chk("rst_mid_cx", 32'(cx), 32'd320);
      chk("rst_mid_cy", 32'(cy), 32'd240);
      chk("rst_mid_color", 32'(color), 32'hCF59);
      chk("rst_mid_tick", 32'(frame_tick), 32'd0);
      ticks = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         if (frame_tick) ticks++;
      end
      chk("rst_mid_noticks", 32'(ticks), 32'd0);
      do_frame(ta, tc);
      chk("post_rst_tick_at", 32'(ta), 32'd3);
      chk("post_rst_cx", 32'(cx), 32'd322);
      chk("post_rst_cy", 32'(cy), 32'd241);
      chk("post_rst_color", 32'(color), 32'hCF59);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
